// File: rtl/mcpu_mem_l1arb.sv
// Two-client round-robin atom arbiter between the instruction/data L1 caches
// and the single memory-arbiter atom port; one atom outstanding at a time.
module mcpu_mem_l1arb #(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_valid,
  input  logic [2:0]    c0_opcode,
  input  logic [31:5]   c0_addr,
  input  logic [255:0]  c0_wdata,
  input  logic [31:0]   c0_wbe,
  output logic [255:0]  c0_rdata,
  output logic          c0_rvalid,
  output logic          c0_stall,
  input  logic          c1_valid,
  input  logic [2:0]    c1_opcode,
  input  logic [31:5]   c1_addr,
  input  logic [255:0]  c1_wdata,
  input  logic [31:0]   c1_wbe,
  output logic [255:0]  c1_rdata,
  output logic          c1_rvalid,
  output logic          c1_stall,
  output logic          arb_valid,
  output logic [2:0]    arb_opcode,
  output logic [31:5]   arb_addr,
  output logic [255:0]  arb_wdata,
  output logic [31:0]   arb_wbe,
  input  logic [255:0]  arb_rdata,
  input  logic          arb_rvalid,
  input  logic          arb_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state_r, state_nxt_s;
  logic       grant_r, grant_nxt_s;
  logic       prio_r, prio_nxt_s;
  logic       win_s, sel_s, arb_valid_s;
  logic [1:0] valid_s, stall_s, rvalid_s;

  assign valid_s = {c1_valid, c0_valid};

  // Round-robin winner: the priority holder if it asks, else the other client.
  always_comb begin
    win_s = prio_r;
    if (valid_s[prio_r]) begin
      win_s = prio_r;
    end else if (valid_s[~prio_r]) begin
      win_s = ~prio_r;
    end else begin
      win_s = prio_r;
    end
  end

  // Next-state, grant/priority update and handshake generation.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    prio_nxt_s  = prio_r;
    sel_s       = 1'b0;
    arb_valid_s = 1'b0;
    stall_s     = 2'b11;
    rvalid_s    = 2'b00;
    case (state_r)
      IDLE: begin
        if (valid_s != 2'b00) begin
          arb_valid_s = 1'b1;
          sel_s       = win_s;
          grant_nxt_s = win_s;
          if (!arb_stall) begin
            stall_s[win_s] = 1'b0;
            state_nxt_s    = WAIT;
          end else begin
            state_nxt_s    = ISSUE;
          end
        end else begin
          sel_s = 1'b0;
        end
      end
      ISSUE: begin
        // Locked to the granted client until downstream takes the atom.
        arb_valid_s = 1'b1;
        sel_s       = grant_r;
        if (!arb_stall) begin
          stall_s[grant_r] = 1'b0;
          state_nxt_s      = WAIT;
        end else begin
          state_nxt_s      = ISSUE;
        end
      end
      WAIT: begin
        if (arb_rvalid) begin
          rvalid_s[grant_r] = 1'b1;
          prio_nxt_s        = ~grant_r;
          state_nxt_s       = IDLE;
        end else begin
          state_nxt_s       = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, grant and priority registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= PRIO_RESET;
      prio_r  <= PRIO_RESET;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      prio_r  <= prio_nxt_s;
    end
  end

  // Handshakes are forced quiet while reset is held.
  assign arb_valid  = arb_valid_s & ~rst;
  assign c0_stall   = stall_s[0] | rst;
  assign c1_stall   = stall_s[1] | rst;
  assign c0_rvalid  = rvalid_s[0] & ~rst;
  assign c1_rvalid  = rvalid_s[1] & ~rst;

  assign arb_opcode = sel_s ? c1_opcode : c0_opcode;
  assign arb_addr   = sel_s ? c1_addr   : c0_addr;
  assign arb_wdata  = sel_s ? c1_wdata  : c0_wdata;
  assign arb_wbe    = sel_s ? c1_wbe    : c0_wbe;

  assign c0_rdata   = arb_rdata;
  assign c1_rdata   = arb_rdata;

endmodule
